// File: rtl/acc_alu_bank_pkg.sv
// Shared opcodes and sequencer states for the accumulator/ALU bank.
package acc_alu_bank_pkg;

    localparam logic [2:0] OP_PASS = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_LOAD = 3'b010;
    localparam logic [2:0] OP_ADD  = 3'b011;
    localparam logic [2:0] OP_NAND = 3'b100;
    localparam logic [2:0] OP_MUL  = 3'b101;

    // Two bits wide so that the unused encodings can be decoded back to idle.
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_MUL  = 2'b01
    } state_e;

endpackage

// File: rtl/acc_alu_bank_alu_core.sv
// Combinational single-cycle ALU: PASS, SUB, LOAD, ADD, NAND; anything else passes a through.
module alu_core
    import acc_alu_bank_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    output logic [WIDTH-1:0] result,
    output logic             carry
);

    logic [WIDTH:0] sum;

    always_comb begin
        result = a;
        carry  = 1'b0;
        sum    = '0;
        case (op)
            OP_SUB: begin
                // A + ~b + 1: the carry-out is the "no borrow" flag (A >= b).
                sum    = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
                result = sum[WIDTH-1:0];
                carry  = sum[WIDTH];
            end
            OP_LOAD: result = b;
            OP_ADD: begin
                sum    = {1'b0, a} + {1'b0, b};
                result = sum[WIDTH-1:0];
                carry  = sum[WIDTH];
            end
            OP_NAND: result = ~(a & b);
            default: result = a;
        endcase
    end

endmodule

// File: rtl/acc_alu_bank.sv
// Accumulator bank with handshaked ALU ops and registered result/flags.
// Define ACC_ALU_BANK_MUL_EN to add the multi-cycle shift-add multiply (opcode 101).
module acc_alu_bank
    import acc_alu_bank_pkg::*;
#(
    parameter  int WIDTH = 4,
    parameter  int NACC  = 2,
    localparam int SELW  = (NACC > 1) ? $clog2(NACC) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [SELW-1:0]  acc_sel,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    output logic [WIDTH-1:0] y,
    output logic             carry,
    output logic             zero
);

    logic [WIDTH-1:0] acc_q [NACC];
    logic [WIDTH-1:0] y_q;
    logic             carry_q;
    logic             zero_q;
    logic             out_valid_q;

    logic [SELW-1:0]  sel;
    logic [WIDTH-1:0] acc_rd;
    logic [WIDTH-1:0] alu_res;
    logic             alu_carry;
    logic             accept;
    logic             is_mul;
    logic             accept_single;

    // Out-of-range selects fall back to accumulator 0.
    always_comb begin
        sel = acc_sel;
        if (32'(acc_sel) >= 32'(NACC)) begin
            sel = '0;
        end
    end

    assign acc_rd = acc_q[sel];

    alu_core #(.WIDTH(WIDTH)) u_alu (
        .a      (acc_rd),
        .b      (b),
        .op     (op),
        .result (alu_res),
        .carry  (alu_carry)
    );

`ifdef ACC_ALU_BANK_MUL_EN
    localparam int CNTW = $clog2(WIDTH);

    state_e             state_q;
    logic [CNTW-1:0]    cnt_q;
    logic [2*WIDTH-1:0] mcand_q;
    logic [WIDTH-1:0]   mplier_q;
    logic [2*WIDTH-1:0] prod_q;
    logic [2*WIDTH-1:0] prod_d;
    logic [SELW-1:0]    tgt_q;

    assign in_ready = (state_q == ST_IDLE);
    assign is_mul   = (op == OP_MUL);
    assign prod_d   = prod_q + (mplier_q[0] ? mcand_q : '0);
`else
    assign in_ready = 1'b1;
    assign is_mul   = 1'b0;
`endif

    assign accept        = in_valid && in_ready;
    assign accept_single = accept && !is_mul;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NACC; i++) begin
                acc_q[i] <= '0;
            end
            y_q         <= '0;
            carry_q     <= 1'b0;
            zero_q      <= 1'b0;
            out_valid_q <= 1'b0;
`ifdef ACC_ALU_BANK_MUL_EN
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            prod_q   <= '0;
            tgt_q    <= '0;
`endif
        end else begin
            out_valid_q <= 1'b0;
            if (accept_single) begin
                acc_q[sel]  <= alu_res;
                y_q         <= alu_res;
                carry_q     <= alu_carry;
                zero_q      <= (alu_res == '0);
                out_valid_q <= 1'b1;
            end
`ifdef ACC_ALU_BANK_MUL_EN
            case (state_q)
                ST_MUL: begin
                    prod_q   <= prod_d;
                    mcand_q  <= mcand_q << 1;
                    mplier_q <= mplier_q >> 1;
                    cnt_q    <= cnt_q - 1'b1;
                    // Terminal count: the last multiplier bit is folded in on this edge.
                    if (cnt_q == '0) begin
                        acc_q[tgt_q] <= prod_d[WIDTH-1:0];
                        y_q          <= prod_d[WIDTH-1:0];
                        carry_q      <= |prod_d[2*WIDTH-1:WIDTH];
                        zero_q       <= (prod_d[WIDTH-1:0] == '0);
                        out_valid_q  <= 1'b1;
                        state_q      <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    if (accept && is_mul) begin
                        state_q  <= ST_MUL;
                        cnt_q    <= CNTW'(WIDTH - 1);
                        mcand_q  <= {{WIDTH{1'b0}}, acc_rd};
                        mplier_q <= b;
                        prod_q   <= '0;
                        tgt_q    <= sel;
                    end
                end
            endcase
`endif
        end
    end

    assign y         = y_q;
    assign carry     = carry_q;
    assign zero      = zero_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_acc_alu_bank.sv
// Self-checking bench for acc_alu_bank at WIDTH=4, NACC=2 (with or without ACC_ALU_BANK_MUL_EN).
module tb_acc_alu_bank;

    localparam int W = 4;
    localparam int N = 2;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [2:0]   op;
    logic [0:0]   acc_sel;
    logic [W-1:0] b;
    logic         out_valid;
    logic [W-1:0] y;
    logic         carry;
    logic         zero;

    int checks = 0;
    int errors = 0;
    int model_acc [N];

    typedef struct {
        int op;
        int sel;
        int bv;
        int ey;
        int ec;
        int ez;
    } vec_t;

    vec_t vecs [12];

    acc_alu_bank #(.WIDTH(W), .NACC(N)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .acc_sel   (acc_sel),
        .b         (b),
        .out_valid (out_valid),
        .y         (y),
        .carry     (carry),
        .zero      (zero)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL global_timeout got running expected finished");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", name, got, exp);
        end
    endtask

    // Reference: plain unsigned arithmetic on integers, modulo 16.
    task automatic model(input int opc, input int sel, input int bv,
                         output int ey, output int ec, output int ez, output int lat);
        int a;
        int p;
        a   = model_acc[sel];
        ey  = a;
        ec  = 0;
        lat = 0;
        case (opc)
            1: begin ey = (a - bv + 16) % 16; ec = (a >= bv) ? 1 : 0; end
            2: ey = bv;
            3: begin ey = (a + bv) % 16; ec = (a + bv >= 16) ? 1 : 0; end
            4: ey = 15 - (a & bv);
`ifdef ACC_ALU_BANK_MUL_EN
            5: begin p = a * bv; ey = p % 16; ec = (p >= 16) ? 1 : 0; lat = W; end
`endif
            default: ey = a;
        endcase
        model_acc[sel] = ey;
        ez = (ey == 0) ? 1 : 0;
    endtask

    task automatic run_op(input int opc, input int sel, input int bv);
        int ey, ec, ez, elat, n, lat;
        model(opc, sel, bv, ey, ec, ez, elat);
        op       = 3'(opc);
        acc_sel  = 1'(sel);
        b        = W'(bv);
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 20) chk("rnd_ready_timeout", 32'(n), 0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < W + 3) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("rnd_latency", 32'(lat), 32'(elat));
        chk("rnd_y", 32'(y), 32'(ey));
        chk("rnd_carry", 32'(carry), 32'(ec));
        chk("rnd_zero", 32'(zero), 32'(ez));
    endtask

    initial begin
        vecs[0]  = '{2, 0, 15, 15, 0, 0};
        vecs[1]  = '{3, 0, 1,  0,  1, 1};
        vecs[2]  = '{2, 1, 5,  5,  0, 0};
        vecs[3]  = '{1, 1, 6,  15, 0, 0};
        vecs[4]  = '{1, 1, 15, 0,  1, 1};
        vecs[5]  = '{0, 0, 9,  0,  0, 1};
        vecs[6]  = '{2, 0, 4,  4,  0, 0};
        vecs[7]  = '{4, 0, 0,  15, 0, 0};
        vecs[8]  = '{0, 0, 3,  15, 0, 0};
        vecs[9]  = '{2, 1, 7,  7,  0, 0};
        vecs[10] = '{6, 1, 2,  7,  0, 0};
        vecs[11] = '{7, 0, 8,  15, 0, 0};

        reset    = 1'b1;
        in_valid = 1'b0;
        op       = '0;
        acc_sel  = '0;
        b        = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_y", 32'(y), 0);
        chk("reset_carry", 32'(carry), 0);
        chk("reset_zero", 32'(zero), 0);
        chk("reset_out_valid", 32'(out_valid), 0);
        chk("reset_in_ready", 32'(in_ready), 1);
        reset = 1'b0;
        @(posedge clk); #1;
        chk("idle_out_valid", 32'(out_valid), 0);

        // Directed table, one command per cycle with in_valid held high.
        for (int i = 0; i < 12; i++) begin
            op       = 3'(vecs[i].op);
            acc_sel  = 1'(vecs[i].sel);
            b        = W'(vecs[i].bv);
            in_valid = 1'b1;
            @(posedge clk); #1;
            chk($sformatf("vec%0d_out_valid", i), 32'(out_valid), 1);
            chk($sformatf("vec%0d_y", i), 32'(y), 32'(vecs[i].ey));
            chk($sformatf("vec%0d_carry", i), 32'(carry), 32'(vecs[i].ec));
            chk($sformatf("vec%0d_zero", i), 32'(zero), 32'(vecs[i].ez));
        end
        in_valid = 1'b0;
        @(posedge clk); #1;
        chk("after_table_out_valid", 32'(out_valid), 0);
        model_acc[0] = 15;
        model_acc[1] = 7;

        // MUL acc1 (7) * 3 with a PASS acc0 command held behind it.
        op = 3'd5; acc_sel = 1'b1; b = 4'd3; in_valid = 1'b1;
        @(posedge clk); #1;
        op = 3'd0; acc_sel = 1'b0; b = 4'd0;
`ifdef ACC_ALU_BANK_MUL_EN
        for (int k = 0; k < W; k++) begin
            chk($sformatf("mul_busy%0d_in_ready", k), 32'(in_ready), 0);
            chk($sformatf("mul_busy%0d_out_valid", k), 32'(out_valid), 0);
            @(posedge clk); #1;
        end
        chk("mul_out_valid", 32'(out_valid), 1);
        chk("mul_y", 32'(y), 5);
        chk("mul_carry", 32'(carry), 1);
        chk("mul_zero", 32'(zero), 0);
        chk("mul_done_in_ready", 32'(in_ready), 1);
        model_acc[1] = 5;
`else
        chk("mul_off_out_valid", 32'(out_valid), 1);
        chk("mul_off_y", 32'(y), 7);
        chk("mul_off_carry", 32'(carry), 0);
        chk("mul_off_in_ready", 32'(in_ready), 1);
`endif
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("held_cmd_out_valid", 32'(out_valid), 1);
        chk("held_cmd_y", 32'(y), 15);

        // Reset two cycles into a MUL.
        op = 3'd5; acc_sel = 1'b1; b = 4'd3; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
        end
        reset = 1'b1;
        #1;
        chk("abort_y", 32'(y), 0);
        chk("abort_carry", 32'(carry), 0);
        chk("abort_zero", 32'(zero), 0);
        chk("abort_out_valid", 32'(out_valid), 0);
        chk("abort_in_ready", 32'(in_ready), 1);
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        chk("post_abort_out_valid", 32'(out_valid), 0);
        model_acc[0] = 0;
        model_acc[1] = 0;
        run_op(0, 1, 0);

        // Randomized commands against the reference model.
        for (int i = 0; i < 80; i++) begin
            run_op(int'($urandom_range(0, 7)), int'($urandom_range(0, N - 1)),
                   int'($urandom_range(0, 15)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
